// File: rtl/ldm_ctrl_if.sv
// Operand-mux side bundle of the LDM/STM sequencer: instruction/control inputs plus beat outputs.
// The sequencer uses the slave view; the EX stage (or a bench) uses the master view.
interface ldm_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          i_is_ldm;
    logic [15:0]   i_reg_list;
    logic          i_pre;
    logic          i_up;
    logic          i_stall;
    logic          i_flush;
    logic [DW-1:0] i_rf_rd_data;

    logic [3:0]    o_rf_rd_code;
    logic [DW-1:0] o_ldm_offset;
    logic          o_ldm_mem_vld;
    logic [3:0]    o_ldm_reg_code;
    logic [DW-1:0] o_ldm_reg;
    logic          o_hold;
    logic          o_done;
    logic [DW-1:0] o_wb_base_offset;

    modport slave (
        input  i_is_ldm, i_reg_list, i_pre, i_up, i_stall, i_flush, i_rf_rd_data,
        output o_rf_rd_code, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_reg,
               o_hold, o_done, o_wb_base_offset
    );

    modport master (
        output i_is_ldm, i_reg_list, i_pre, i_up, i_stall, i_flush, i_rf_rd_data,
        input  o_rf_rd_code, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_reg,
               o_hold, o_done, o_wb_base_offset
    );
endinterface

// File: rtl/ldm_ctrl.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first, one beat per register,
// holding the pipeline until the final beat is accepted, then reports the base write-back offset.
module ldm_ctrl #(
    parameter int unsigned DW   = 32,
    parameter int unsigned STEP = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ldm_ctrl_if.slave      bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]    r_state;
    logic [15:0]   r_rem;
    logic [DW-1:0] r_off;
    logic [4:0]    r_n;
    logic          r_up;

    logic [0:0]    w_state_nxt;
    logic [15:0]   w_rem_nxt;
    logic [DW-1:0] w_off_nxt;
    logic [4:0]    w_n_nxt;
    logic          w_up_nxt;

    logic [4:0]    w_cnt;
    logic [3:0]    w_low;
    logic          w_last;
    logic [DW-1:0] w_step;
    logic [DW-1:0] w_span_in;
    logic [DW-1:0] w_span_n;

    logic          w_hold;
    logic          w_done;
    logic          w_vld;
    logic [3:0]    w_code;
    logic [DW-1:0] w_offset;
    logic [DW-1:0] w_wb;

    // List statistics: incoming popcount, lowest pending register, last-beat detect.
    always_comb begin
        w_cnt = 5'd0;
        w_low = 4'd0;
        for (int k = 0; k < 16; k++) begin
            w_cnt = w_cnt + 5'(bus.i_reg_list[k]);
        end
        for (int k = 15; k >= 0; k--) begin
            if (r_rem[k]) w_low = 4'(k);
        end
        w_last = ((r_rem & (r_rem - 16'd1)) == 16'd0);
    end

    assign w_step    = DW'(STEP);
    assign w_span_in = DW'(STEP * 32'(w_cnt));
    assign w_span_n  = DW'(STEP * 32'(r_n));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= 16'd0;
            r_off   <= '0;
            r_n     <= 5'd0;
            r_up    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_off   <= w_off_nxt;
            r_n     <= w_n_nxt;
            r_up    <= w_up_nxt;
        end
    end

    // Next state and beat outputs; flush (and reset) override everything and silence all outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_off_nxt   = r_off;
        w_n_nxt     = r_n;
        w_up_nxt    = r_up;
        w_hold      = 1'b0;
        w_done      = 1'b0;
        w_vld       = 1'b0;
        w_code      = 4'd0;
        w_offset    = '0;
        w_wb        = '0;

        if (!i_rst_n || bus.i_flush) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_is_ldm) begin
                        if (bus.i_reg_list == 16'd0) begin
                            w_done = 1'b1;
                        end else begin
                            w_rem_nxt   = bus.i_reg_list;
                            w_n_nxt     = w_cnt;
                            w_up_nxt    = bus.i_up;
                            w_hold      = 1'b1;
                            w_state_nxt = S_XFER;
                            // Start at the lowest address of the block so beats always ascend.
                            case ({bus.i_pre, bus.i_up})
                                2'b01:   w_off_nxt = '0;
                                2'b11:   w_off_nxt = w_step;
                                2'b00:   w_off_nxt = w_step - w_span_in;
                                default: w_off_nxt = '0 - w_span_in;
                            endcase
                        end
                    end
                end
                S_XFER: begin
                    w_vld    = 1'b1;
                    w_code   = w_low;
                    w_offset = r_off;
                    if (bus.i_stall) begin
                        w_hold = 1'b1;
                    end else if (!w_last) begin
                        w_rem_nxt = r_rem & (r_rem - 16'd1);
                        w_off_nxt = r_off + w_step;
                        w_hold    = 1'b1;
                    end else begin
                        w_done      = 1'b1;
                        w_wb        = r_up ? w_span_n : ('0 - w_span_n);
                        w_rem_nxt   = 16'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = 16'd0;
                end
            endcase
        end
    end

    assign bus.o_hold           = w_hold;
    assign bus.o_done           = w_done;
    assign bus.o_ldm_mem_vld    = w_vld;
    assign bus.o_ldm_reg_code   = w_code;
    assign bus.o_rf_rd_code     = w_code;
    assign bus.o_ldm_offset     = w_offset;
    assign bus.o_wb_base_offset = w_wb;
    assign bus.o_ldm_reg        = w_vld ? bus.i_rf_rd_data : '0;
endmodule

// File: tb/tb_ldm_ctrl.sv
// Directed bench for ldm_ctrl: each step drives inputs, then checks every output against hand values.
module tb_ldm_ctrl;
    localparam logic [31:0] RD = 32'hCAFE_F00D;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ldm_ctrl_if #(.DW(32)) bus ();

    ldm_ctrl #(.DW(32), .STEP(4)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all outputs mid-cycle, then advance to the input phase of the next cycle.
    task automatic cyc(input string tag, input logic h, input logic d, input logic v,
                       input logic [3:0] c, input logic [31:0] o, input logic [31:0] w);
        #2;
        chk({tag, ".hold"}, 32'(bus.o_hold), 32'(h));
        chk({tag, ".done"}, 32'(bus.o_done), 32'(d));
        chk({tag, ".vld"},  32'(bus.o_ldm_mem_vld), 32'(v));
        chk({tag, ".code"}, 32'(bus.o_ldm_reg_code), 32'(c));
        chk({tag, ".rdcode"}, 32'(bus.o_rf_rd_code), 32'(c));
        chk({tag, ".off"},  bus.o_ldm_offset, o);
        chk({tag, ".wb"},   bus.o_wb_base_offset, w);
        chk({tag, ".reg"},  bus.o_ldm_reg, v ? RD : 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic setup(input logic is_ldm, input logic [15:0] list, input logic pre, input logic up);
        bus.i_is_ldm   = is_ldm;
        bus.i_reg_list = list;
        bus.i_pre      = pre;
        bus.i_up       = up;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_rf_rd_data = RD;
        setup(1'b1, 16'h000E, 1'b0, 1'b1);
        #2;
        cyc("rst", 0, 0, 0, 4'd0, 32'd0, 32'd0);
        cyc("rst2", 0, 0, 0, 4'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        bus.i_is_ldm = 1'b0;
        cyc("idle", 0, 0, 0, 4'd0, 32'd0, 32'd0);

        // IA 0x000E
        setup(1'b1, 16'h000E, 1'b0, 1'b1);
        cyc("t1.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        cyc("t1.b1",  1, 0, 1, 4'd1, 32'd0, 32'd0);
        cyc("t1.b2",  1, 0, 1, 4'd2, 32'd4, 32'd0);
        cyc("t1.b3",  0, 1, 1, 4'd3, 32'd8, 32'd12);
        bus.i_is_ldm = 1'b0;
        cyc("t1.idle", 0, 0, 0, 4'd0, 32'd0, 32'd0);

        // DB 0x8001
        setup(1'b1, 16'h8001, 1'b1, 1'b0);
        cyc("t2.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        cyc("t2.b1",  1, 0, 1, 4'd0,  32'hFFFF_FFF8, 32'd0);
        cyc("t2.b2",  0, 1, 1, 4'd15, 32'hFFFF_FFFC, 32'hFFFF_FFF8);

        // IB 0x0010 with two stall cycles
        setup(1'b1, 16'h0010, 1'b1, 1'b1);
        cyc("t3.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        bus.i_stall  = 1'b1;
        cyc("t3.s1",  1, 0, 1, 4'd4, 32'd4, 32'd0);
        cyc("t3.s2",  1, 0, 1, 4'd4, 32'd4, 32'd0);
        bus.i_stall  = 1'b0;
        cyc("t3.b1",  0, 1, 1, 4'd4, 32'd4, 32'd4);

        // Empty list: same-cycle done
        setup(1'b1, 16'h0000, 1'b0, 1'b1);
        cyc("t4.empty", 0, 1, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        cyc("t4.idle",  0, 0, 0, 4'd0, 32'd0, 32'd0);

        // Flush beats accept
        setup(1'b1, 16'h000E, 1'b0, 1'b1);
        bus.i_flush = 1'b1;
        cyc("fa.acc", 0, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_flush  = 1'b0;
        bus.i_is_ldm = 1'b0;
        cyc("fa.idle", 0, 0, 0, 4'd0, 32'd0, 32'd0);

        // DA 0xFFFF full run
        setup(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc("t5.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc($sformatf("t5.b%0d", k), (k != 15), (k == 15), 1, 4'(k),
                32'hFFFF_FFC4 + 32'(4 * k), (k == 15) ? 32'hFFFF_FFC0 : 32'd0);
        end

        // DA 0xFFFF, flush (together with stall) at the fifth beat
        setup(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc("t5f.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("t5f.b%0d", k), 1, 0, 1, 4'(k), 32'hFFFF_FFC4 + 32'(4 * k), 32'd0);
        end
        bus.i_flush = 1'b1;
        bus.i_stall = 1'b1;
        cyc("t5f.fl", 0, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("t5f.post%0d", k), 0, 0, 0, 4'd0, 32'd0, 32'd0);
        end

        // DA 0xFFFF, async reset at the fifth beat
        setup(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc("t5r.acc", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        bus.i_is_ldm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("t5r.b%0d", k), 1, 0, 1, 4'(k), 32'hFFFF_FFC4 + 32'(4 * k), 32'd0);
        end
        rst_n = 1'b0;
        cyc("t5r.rst", 0, 0, 0, 4'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("t5r.post%0d", k), 0, 0, 0, 4'd0, 32'd0, 32'd0);
        end

        // Back-to-back IA 0x0003; i_is_ldm stays high throughout
        setup(1'b1, 16'h0003, 1'b0, 1'b1);
        cyc("t6.acc1", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        cyc("t6.b1",   1, 0, 1, 4'd0, 32'd0, 32'd0);
        cyc("t6.b2",   0, 1, 1, 4'd1, 32'd4, 32'd8);
        cyc("t6.acc2", 1, 0, 0, 4'd0, 32'd0, 32'd0);
        cyc("t6.b4",   1, 0, 1, 4'd0, 32'd0, 32'd0);
        cyc("t6.b5",   0, 1, 1, 4'd1, 32'd4, 32'd8);
        bus.i_is_ldm = 1'b0;
        cyc("t6.idle", 0, 0, 0, 4'd0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
